// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, NOP word, PC increment.
// Pure declarations; no latency or backpressure of its own.
package riscv_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } ifu_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Instruction addresses are word aligned; the low two bits of any target are ignored.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: hazard/redirect inputs, instruction-memory port and IF/ID outputs.
// master = fetch unit side, slave = surrounding pipeline and memory.
interface instruction_fetch_unit_if;

  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_readdata;
  logic        imem_busywait;
  logic [31:0] PC;
  logic [31:0] nextPC;
  logic [31:0] Instruction;
  logic        Insthit;
  logic        busywait;

  modport master (
    input  stall, branch_taken, branch_target, imem_readdata, imem_busywait,
    output imem_read, imem_address, PC, nextPC, Instruction, Insthit, busywait
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_readdata, imem_busywait,
    input  imem_read, imem_address, PC, nextPC, Instruction, Insthit, busywait
  );

endinterface

// File: rtl/ifu_skid_buffer.sv
// One-entry holding register for an instruction word returned while the pipeline is stalled.
// Load has priority over drain; flush and reset empty it. Zero-latency read of the held word.
module ifu_skid_buffer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        drain,
  input  logic        flush,
  input  logic [31:0] load_data,
  output logic        full,
  output logic [31:0] data
);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end

    if (reset) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, issues word reads, handles stall, redirect and memory busywait.
// Outputs are combinational within the cycle; IFU_SKID_BUF_EN keeps data returned during a stall.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  instruction_fetch_unit_if.master bus
);

  ifu_state_t  state_q;
  logic [31:0] pc_q;
  logic [31:0] target_q;

  logic        read_req;
  logic        complete;
  logic        hit;
  logic        skid_full;
  logic [31:0] skid_data;
  logic [31:0] branch_addr;

  assign branch_addr = word_align(bus.branch_target);

  // A full skid buffer already holds the word at PC, so no new read is needed.
  always_comb begin
    read_req = 1'b0;
    case (state_q)
      FETCH:         read_req = (!bus.stall || bus.branch_taken) && !skid_full;
      WAIT, DISCARD: read_req = 1'b1;
      default:       read_req = 1'b0;
    endcase
    if (reset) read_req = 1'b0;
  end

  assign complete = read_req && !bus.imem_busywait;

  always_comb begin
    hit = 1'b0;
    if (!reset && !bus.branch_taken && !bus.stall) begin
      case (state_q)
        FETCH:   hit = skid_full || complete;
        WAIT:    hit = complete;
        default: hit = 1'b0;
      endcase
    end
  end

`ifdef IFU_SKID_BUF_EN
  logic skid_load;
  logic skid_drain;

  assign skid_load  = (state_q == WAIT) && !bus.imem_busywait && bus.stall && !bus.branch_taken;
  assign skid_drain = hit && skid_full;

  ifu_skid_buffer u_skid (
    .clock     (clock),
    .reset     (reset),
    .load      (skid_load),
    .drain     (skid_drain),
    .flush     (bus.branch_taken),
    .load_data (bus.imem_readdata),
    .full      (skid_full),
    .data      (skid_data)
  );
`else
  assign skid_full = 1'b0;
  assign skid_data = INSTR_NOP;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      state_q  <= FETCH;
      target_q <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (skid_full) begin
            if (bus.branch_taken)  pc_q <= branch_addr;
            else if (!bus.stall)   pc_q <= pc_q + PC_STEP;
          end else if (read_req) begin
            if (!bus.imem_busywait) begin
              pc_q <= bus.branch_taken ? branch_addr : pc_q + PC_STEP;
            end else if (bus.branch_taken) begin
              target_q <= branch_addr;
              state_q  <= DISCARD;
            end else begin
              state_q  <= WAIT;
            end
          end
        end

        WAIT: begin
          if (bus.imem_busywait) begin
            if (bus.branch_taken) begin
              target_q <= branch_addr;
              state_q  <= DISCARD;
            end
          end else begin
            // Data returned under stall is either captured by the skid buffer or dropped.
            state_q <= FETCH;
            if (bus.branch_taken)  pc_q <= branch_addr;
            else if (!bus.stall)   pc_q <= pc_q + PC_STEP;
          end
        end

        DISCARD: begin
          if (bus.imem_busywait) begin
            if (bus.branch_taken) target_q <= branch_addr;
          end else begin
            state_q <= FETCH;
            pc_q    <= bus.branch_taken ? branch_addr : target_q;
          end
        end

        default: state_q <= FETCH;
      endcase
    end
  end

  assign bus.imem_read    = read_req;
  assign bus.imem_address = pc_q;
  assign bus.PC           = pc_q;
  assign bus.nextPC       = pc_q + PC_STEP;
  assign bus.Insthit      = hit;
  assign bus.Instruction  = !hit ? INSTR_NOP : (skid_full ? skid_data : bus.imem_readdata);
  assign bus.busywait     = read_req && bus.imem_busywait;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed cycle table for the fetch stage with a scoreboard of expected fetched addresses.
// Memory returns a hashed word per address so misrouted data is visible.
module tb_instruction_fetch_unit;
  import riscv_pkg::*;

  localparam bit SKID =
`ifdef IFU_SKID_BUF_EN
    1'b1;
`else
    1'b0;
`endif

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(.RESET_PC(32'h100)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_readdata = mem_word(bus.imem_address);

  typedef struct {
    bit          rst;
    bit          stall;
    bit          br;
    logic [31:0] tgt;
    bit          busy;
    bit          rd;
    logic [31:0] addr;
    bit          hit;
  } row_t;

  row_t        rows[$];
  logic [31:0] sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic add(input bit rst, input bit stall, input bit br, input logic [31:0] tgt,
                     input bit busy, input bit rd, input logic [31:0] addr, input bit hit);
    rows.push_back('{rst, stall, br, tgt, busy, rd, addr, hit});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t        r;
    logic [31:0] a;

    // rst stall br  target         busy  rd     addr           hit
    add(0, 0, 0, 32'h0,          0, 1,     32'h100,       1);
    add(0, 0, 0, 32'h0,          1, 1,     32'h104,       0);
    add(0, 0, 0, 32'h0,          1, 1,     32'h104,       0);
    add(0, 0, 0, 32'h0,          1, 1,     32'h104,       0);
    add(0, 0, 0, 32'h0,          0, 1,     32'h104,       1);
    add(0, 0, 0, 32'h0,          0, 1,     32'h108,       1);
    add(0, 0, 0, 32'h0,          1, 1,     32'h10C,       0);
    add(0, 0, 1, 32'h200,        1, 1,     32'h10C,       0);
    add(0, 0, 0, 32'h0,          1, 1,     32'h10C,       0);
    add(0, 0, 0, 32'h0,          0, 1,     32'h10C,       0);
    add(0, 0, 0, 32'h0,          0, 1,     32'h200,       1);
    add(0, 0, 1, 32'h112,        0, 1,     32'h204,       0);
    add(0, 1, 0, 32'h0,          0, 0,     32'h110,       0);
    add(0, 1, 0, 32'h0,          0, 0,     32'h110,       0);
    add(0, 0, 0, 32'h0,          0, 1,     32'h110,       1);
    add(0, 0, 0, 32'h0,          1, 1,     32'h114,       0);
    add(0, 1, 0, 32'h0,          0, 1,     32'h114,       0);
    add(0, 1, 0, 32'h0,          0, 0,     32'h114,       0);
    add(0, 0, 0, 32'h0,          0, !SKID, 32'h114,       1);
    add(0, 0, 0, 32'h0,          1, 1,     32'h118,       0);
    add(0, 1, 0, 32'h0,          0, 1,     32'h118,       0);
    add(0, 0, 1, 32'hFFFF_FFFC,  0, !SKID, 32'h118,       0);
    add(0, 0, 0, 32'h0,          0, 1,     32'hFFFF_FFFC, 1);
    add(0, 0, 0, 32'h0,          0, 1,     32'h0,         1);
    add(0, 0, 0, 32'h0,          1, 1,     32'h4,         0);
    add(0, 0, 1, 32'h300,        1, 1,     32'h4,         0);
    add(0, 0, 1, 32'h400,        1, 1,     32'h4,         0);
    add(0, 0, 0, 32'h0,          0, 1,     32'h4,         0);
    add(0, 0, 0, 32'h0,          0, 1,     32'h400,       1);
    add(0, 1, 1, 32'h500,        0, 1,     32'h404,       0);
    add(0, 0, 0, 32'h0,          1, 1,     32'h500,       0);
    add(1, 0, 0, 32'h0,          1, 0,     32'h500,       0);
    add(0, 0, 0, 32'h0,          0, 1,     32'h100,       1);
    add(0, 0, 0, 32'h0,          0, 1,     32'h104,       1);

    reset               = 1'b1;
    bus.stall           = 1'b0;
    bus.branch_taken    = 1'b0;
    bus.branch_target   = 32'h0;
    bus.imem_busywait   = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_imem_read",   32'(bus.imem_read), 32'd0);
    check("rst_insthit",     32'(bus.Insthit),   32'd0);
    check("rst_busywait",    32'(bus.busywait),  32'd0);
    check("rst_instruction", bus.Instruction,    INSTR_NOP);
    check("rst_pc",          bus.PC,             32'h100);

    foreach (rows[i]) begin
      r = rows[i];
      @(posedge clock);
      #1;
      reset             = r.rst;
      bus.stall         = r.stall;
      bus.branch_taken  = r.br;
      bus.branch_target = r.tgt;
      bus.imem_busywait = r.busy;
      if (r.hit) sb.push_back(r.addr);
      @(negedge clock);
      check($sformatf("imem_read[%0d]", i),    32'(bus.imem_read), 32'(r.rd));
      check($sformatf("imem_address[%0d]", i), bus.imem_address,   r.addr);
      check($sformatf("nextPC[%0d]", i),       bus.nextPC,         r.addr + 32'd4);
      check($sformatf("busywait[%0d]", i),     32'(bus.busywait),  32'(r.rd && r.busy));
      check($sformatf("insthit[%0d]", i),      32'(bus.Insthit),   32'(r.hit));
      if (bus.Insthit) begin
        if (sb.size() == 0) begin
          check($sformatf("sb_underflow[%0d]", i), 32'(sb.size()), 32'd1);
        end else begin
          a = sb.pop_front();
          check($sformatf("hit_pc[%0d]", i),    bus.PC,          a);
          check($sformatf("hit_instr[%0d]", i), bus.Instruction, mem_word(a));
        end
      end else begin
        check($sformatf("nop[%0d]", i), bus.Instruction, INSTR_NOP);
      end
    end

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage of the 5-stage RISC-V pipeline. Holds the program counter and issues word reads to instruction memory. Delivers `PC`, `nextPC`, `Instruction` and `Insthit` to the IF/ID pipeline register. Handles three cases:
- load-use stalls;
- taken branch/jump redirects from the ALU stage, including a redirect that arrives while a memory read is outstanding;
- instruction-memory busywait.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

Ports:
- `clock`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  load-use freeze from the hazard unit; PC holds.
- `branch_taken`  in  1  redirect request from the ALU stage.
- `branch_target`  in  32  redirect address; bits [1:0] ignored (treated as 00).
- `imem_read`  out  1  instruction-memory read request.
- `imem_address`  out  32  read address; always equals `PC`.
- `imem_readdata`  in  32  instruction word, valid when `imem_busywait`=0.
- `imem_busywait`  in  1  memory not ready.
- `PC`  out  32  address of the current fetch.
- `nextPC`  out  32  `PC`+4, modulo 2^32.
- `Instruction`  out  32  fetched word; 32'h0000_0013 (NOP) whenever `Insthit`=0.
- `Insthit`  out  1  `Instruction` is valid and must be executed.
- `busywait`  out  1  `imem_read` & `imem_busywait`; freezes downstream pipeline registers.

## Operation
- FSM states:
  - FETCH: no request outstanding.
  - WAIT: request outstanding, memory busy.
  - DISCARD: outstanding request whose data must be dropped.
- FETCH
  - `imem_read` = !`stall` | `branch_taken`.
  - If the memory completes in the same cycle (`imem_busywait`=0) and no branch: `Insthit`=1, `Instruction`=`imem_readdata`, PC<=PC+4.
  - If `imem_busywait`=1: go to WAIT.
- WAIT
  - `imem_read` held at 1 and address held until `imem_busywait`=0.
  - On completion with no stall and no branch: `Insthit`=1, PC<=PC+4, go to FETCH.
- Redirect (`branch_taken`=1)
  - Priority over `stall`, which is ignored that cycle. `Insthit`=0.
  - In FETCH or WAIT with memory complete this cycle: PC<=target, go to FETCH.
  - In WAIT with memory still busy: latch the target, go to DISCARD.
- DISCARD
  - Holds `imem_read` until `imem_busywait`=0, then drops the data (`Insthit`=0), PC<=latched target, goes to FETCH.
  - A second `branch_taken` while in DISCARD overwrites the latched target.
- Stall
  - `stall`=1 in FETCH: no new request, PC holds, `Insthit`=0.
  - `stall`=1 in WAIT when data returns: behaviour per Configuration; PC holds in both cases.
- Address arithmetic is 32-bit unsigned with wrap-around: 32'hFFFF_FFFC+4 = 32'h0000_0000.

## Timing
- Reset, sampled at a rising edge:
  - PC<=`RESET_PC`, state<=FETCH, latched target<=0, skid buffer emptied.
  - While `reset`=1: `imem_read`=0, `Insthit`=0, `busywait`=0, `Instruction`=NOP.
  - Reset asserted mid-WAIT/DISCARD abandons the request; the first request after reset is to `RESET_PC`.
- `Insthit`, `Instruction`, `busywait` and `imem_read` are combinational from state, `PC`, the memory signals, `stall` and `branch_taken`. They are sampled by the IF/ID register at the next rising edge.
- Zero-wait memory: one instruction per cycle.
- N busy cycles: `Insthit` asserts in cycle N+1 of the request.
- Redirect: the target is requested in the cycle after the redirect (FETCH or WAIT-complete), or in the cycle after DISCARD completes.

## Configuration
- `IFU_SKID_BUF_EN` defined:
  - A one-entry skid buffer captures `imem_readdata` returned in WAIT while `stall`=1.
  - While full: no memory request is issued.
  - First cycle with `stall`=0: the buffered word is presented with `Insthit`=1, the buffer empties, PC<=PC+4.
  - `branch_taken` empties the buffer without delivering it.
- Undefined: the returned data is dropped and the state goes to FETCH. The same PC is re-requested after the stall (one extra memory access).

## Structure
- Shared package `riscv_pkg`:
  - FSM state enum (FETCH, WAIT, DISCARD);
  - `INSTR_NOP` = 32'h0000_0013;
  - `PC_STEP` = 4.
- One sub-module, `ifu_skid_buffer`: data register plus valid flag, with load, drain and flush inputs. It is instantiated only under `IFU_SKID_BUF_EN`.

## Test plan
- Reset with `RESET_PC`=32'h100, zero-wait memory → `imem_address`=0x100, 0x104, 0x108 on consecutive cycles, `Insthit`=1 each cycle.
- `imem_busywait` high 3 cycles at PC 0x104 → `busywait`=1 for 3 cycles, address held at 0x104, `Insthit`=1 in cycle 4, then PC=0x108.
- `branch_taken` with target 0x200 during WAIT at 0x10C → data at 0x10C dropped (`Insthit`=0), next request at 0x200.
- `stall` for 2 cycles in FETCH at 0x110 → no request, PC holds at 0x110, then fetches 0x110.
- Data returns during `stall`:
  - with `IFU_SKID_BUF_EN`: `Insthit`=1 for the buffered word on the first unstalled cycle, with no memory access;
  - without it: 0x114 is re-requested.
- PC=32'hFFFF_FFFC, zero-wait memory → `nextPC`=0, next fetch at 0. `reset` asserted during WAIT → next request at `RESET_PC`.
